// File: rtl/systolic_conv_array_pkg.sv
// rtl/systolic_conv_array_pkg.sv - shared state encoding and sizing helper for the systolic conv array
package systolic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_OUTPUT  = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Ceiling log2, never below 1 so single-entry ranges still get a real bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/systolic_conv_array_if.sv
// rtl/systolic_conv_array_if.sv - load, control and result-stream bundle of the systolic conv array
interface systolic_conv_array_if import systolic_pkg::*; #(
  parameter int N     = 4,
  parameter int K     = 3,
  parameter int DW    = 8,
  parameter int OUT_W = 8
);
  localparam int OH  = N - K + 1;
  localparam int AW  = clog2(N * N);
  localparam int OAW = clog2(OH * OH);

  logic             ld_valid;
  logic             ld_sel;
  logic [AW-1:0]    ld_addr;
  logic [DW-1:0]    ld_data;
  logic             start;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [OAW-1:0]   out_idx;
  logic [OUT_W-1:0] out_data;
  logic             done;

  modport master (
    output ld_valid, ld_sel, ld_addr, ld_data, start, out_ready,
    input  busy, out_valid, out_idx, out_data, done
  );

  modport slave (
    input  ld_valid, ld_sel, ld_addr, ld_data, start, out_ready,
    output busy, out_valid, out_idx, out_data, done
  );

endinterface

// File: rtl/systolic_conv_array_pe.sv
// rtl/systolic_conv_array_pe.sv - output-stationary multiply-accumulate processing element
module conv_pe #(
  parameter int DW    = 8,
  parameter int ACC_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [DW-1:0]    a,
  input  logic [DW-1:0]    w,
  output logic [ACC_W-1:0] acc
);

  logic [2*DW-1:0] prod;
  assign prod = {{DW{1'b0}}, a} * {{DW{1'b0}}, w};

  // clr together with en restarts the sum with the current product.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= (clr ? '0 : acc) + ACC_W'(prod);
    end else if (clr) begin
      acc <= '0;
    end
  end

endmodule

// File: rtl/systolic_conv_array.sv
// rtl/systolic_conv_array.sv - valid 2-D convolution on an output-stationary PE grid with streamed results
module systolic_conv_array import systolic_pkg::*; #(
  parameter int N      = 4,
  parameter int K      = 3,
  parameter int DW     = 8,
  parameter int ACC_W  = 20,
  parameter int OUT_W  = 8,
  parameter int ROTATE = 0,
  parameter int SAT    = 1
) (
  input logic             clk,
  input logic             rst,
  systolic_conv_array_if.slave bus
);

  localparam int OH   = N - K + 1;
  localparam int NOUT = OH * OH;
  localparam int AW   = clog2(N * N);
  localparam int OAW  = clog2(NOUT);
  localparam int KAW  = clog2(K * K);
  localparam int RW   = clog2(K);
  localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'((64'd1 << OUT_W) - 64'd1);

  state_t           state;
  logic [RW-1:0]    r_idx;
  logic [RW-1:0]    c_idx;
  logic [OAW-1:0]   out_idx;
  logic             busy_q;
  logic             out_valid_q;
  logic             done_q;
  logic [DW-1:0]    ifm_mem  [N*N];
  logic [DW-1:0]    kern_mem [K*K];
  logic [ACC_W-1:0] acc      [NOUT];

  logic             last_tap;
  logic             pe_en;
  logic             pe_clr;
  logic [KAW-1:0]   w_addr;
  logic [DW-1:0]    weight;
  logic [ACC_W-1:0] sel_acc;
  logic [OUT_W-1:0] out_data_c;

  assign last_tap = (int'(r_idx) == K - 1) && (int'(c_idx) == K - 1);
  assign pe_en    = (state == ST_COMPUTE);
  assign pe_clr   = pe_en && (r_idx == '0) && (c_idx == '0);

  // The same tap weight is broadcast to every PE; ROTATE walks the kernel back to front.
  always_comb begin
    w_addr = KAW'(int'(r_idx) * K + int'(c_idx));
    if (ROTATE != 0) begin
      w_addr = KAW'((K - 1 - int'(r_idx)) * K + (K - 1 - int'(c_idx)));
    end
  end
  assign weight = kern_mem[w_addr];

  for (genvar gi = 0; gi < OH; gi++) begin : g_row
    for (genvar gj = 0; gj < OH; gj++) begin : g_col
      logic [AW-1:0] a_addr;
      assign a_addr = AW'((gi + int'(r_idx)) * N + gj + int'(c_idx));

      conv_pe #(
        .DW    (DW),
        .ACC_W (ACC_W)
      ) u_pe (
        .clk (clk),
        .rst (rst),
        .clr (pe_clr),
        .en  (pe_en),
        .a   (ifm_mem[a_addr]),
        .w   (weight),
        .acc (acc[gi*OH+gj])
      );
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      r_idx       <= '0;
      c_idx       <= '0;
      out_idx     <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < N * N; i++) ifm_mem[i] <= '0;
      for (int i = 0; i < K * K; i++) kern_mem[i] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.ld_valid) begin
            if (!bus.ld_sel) begin
              if (int'(bus.ld_addr) < N * N) ifm_mem[bus.ld_addr] <= bus.ld_data;
            end else if (int'(bus.ld_addr) < K * K) begin
              kern_mem[bus.ld_addr[KAW-1:0]] <= bus.ld_data;
            end
          end
          if (bus.start) begin
            state  <= ST_COMPUTE;
            busy_q <= 1'b1;
            r_idx  <= '0;
            c_idx  <= '0;
          end
        end
        ST_COMPUTE: begin
          if (last_tap) begin
            state       <= ST_OUTPUT;
            out_valid_q <= 1'b1;
            out_idx     <= '0;
          end else if (int'(c_idx) == K - 1) begin
            c_idx <= '0;
            r_idx <= r_idx + 1'b1;
          end else begin
            c_idx <= c_idx + 1'b1;
          end
        end
        ST_OUTPUT: begin
          if (bus.out_ready) begin
            if (int'(out_idx) == NOUT - 1) begin
              state       <= ST_DONE;
              out_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              out_idx <= out_idx + 1'b1;
            end
          end
        end
        ST_DONE: begin
          state   <= ST_IDLE;
          out_idx <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Accumulators only become visible while a result is being offered.
  always_comb begin
    sel_acc    = acc[out_idx];
    out_data_c = '0;
    if (out_valid_q) begin
      if (SAT != 0 && sel_acc > SAT_MAX) out_data_c = {OUT_W{1'b1}};
      else                               out_data_c = sel_acc[OUT_W-1:0];
    end
  end

  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_idx   = out_idx;
  assign bus.out_data  = out_data_c;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_systolic_conv_array.sv
// tb/tb_systolic_conv_array.sv - directed bench for correlation, rotation, wrap/saturate and stream control
module tb_systolic_conv_array;

  logic       clk = 1'b0;
  logic       rst;
  logic       ld_valid;
  logic       ld_sel;
  logic [3:0] ld_addr;
  logic [7:0] ld_data;
  logic       start;
  logic       out_ready;

  int n_checks = 0;
  int n_fail   = 0;
  int ifm_a  [16];
  int kern_a [9];
  int res_c  [8];
  int res_r  [8];
  int res_w  [8];
  int idx_c  [8];
  int st_idx [8];
  int st_data[8];
  int hs_c, hs_r, hs_w, done_at, n_stall;

  always #5 clk = ~clk;

  systolic_conv_array_if #(.N(4), .K(3), .DW(8), .OUT_W(8)) if_c ();
  systolic_conv_array_if #(.N(4), .K(3), .DW(8), .OUT_W(8)) if_r ();
  systolic_conv_array_if #(.N(4), .K(3), .DW(8), .OUT_W(8)) if_w ();

  assign if_c.ld_valid = ld_valid;  assign if_r.ld_valid = ld_valid;  assign if_w.ld_valid = ld_valid;
  assign if_c.ld_sel   = ld_sel;    assign if_r.ld_sel   = ld_sel;    assign if_w.ld_sel   = ld_sel;
  assign if_c.ld_addr  = ld_addr;   assign if_r.ld_addr  = ld_addr;   assign if_w.ld_addr  = ld_addr;
  assign if_c.ld_data  = ld_data;   assign if_r.ld_data  = ld_data;   assign if_w.ld_data  = ld_data;
  assign if_c.start    = start;     assign if_r.start    = start;     assign if_w.start    = start;
  assign if_c.out_ready = out_ready; assign if_r.out_ready = out_ready; assign if_w.out_ready = out_ready;

  systolic_conv_array #(.N(4), .K(3), .DW(8), .ACC_W(20), .OUT_W(8), .ROTATE(0), .SAT(1))
    dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));
  systolic_conv_array #(.N(4), .K(3), .DW(8), .ACC_W(20), .OUT_W(8), .ROTATE(1), .SAT(1))
    dut_r (.clk(clk), .rst(rst), .bus(if_r.slave));
  systolic_conv_array #(.N(4), .K(3), .DW(8), .ACC_W(20), .OUT_W(8), .ROTATE(0), .SAT(0))
    dut_w (.clk(clk), .rst(rst), .bus(if_w.slave));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_ifm;
    for (int i = 0; i < 16; i++) begin
      ld_valid = 1'b1; ld_sel = 1'b0; ld_addr = 4'(i); ld_data = 8'(ifm_a[i]);
      tick;
    end
    ld_valid = 1'b0;
  endtask

  task automatic load_kern(input int count);
    for (int i = 0; i < count; i++) begin
      ld_valid = 1'b1; ld_sel = 1'b1; ld_addr = 4'(i); ld_data = 8'(kern_a[i]);
      tick;
    end
    ld_valid = 1'b0;
  endtask

  // Drives one start-to-done run on all three DUTs and records every handshake.
  task automatic run(input int stall_idx, input int stall_len, input bit inject, input bit with_write);
    int n;
    hs_c = 0; hs_r = 0; hs_w = 0; done_at = -1; n_stall = 0;
    out_ready = 1'b1;
    start = 1'b1;
    if (with_write) begin
      ld_valid = 1'b1; ld_sel = 1'b1; ld_addr = 4'd8; ld_data = 8'(kern_a[8]);
    end
    tick;
    start = 1'b0; ld_valid = 1'b0;
    n = 1;
    while (n < 80 && done_at < 0) begin
      if (if_c.done) begin
        done_at = n;
      end else begin
        out_ready = 1'b1;
        if (stall_len > 0 && if_c.out_valid && int'(if_c.out_idx) == stall_idx && n_stall < stall_len) begin
          out_ready = 1'b0;
          st_idx[n_stall]  = int'(if_c.out_idx);
          st_data[n_stall] = int'(if_c.out_data);
          n_stall++;
        end
        if (inject && (n == 3 || n == 11)) begin
          start = 1'b1; ld_valid = 1'b1; ld_sel = 1'b1; ld_addr = 4'd0; ld_data = 8'd7;
        end else begin
          start = 1'b0; ld_valid = 1'b0;
        end
        if (if_c.out_valid && out_ready) begin
          if (hs_c < 8) begin res_c[hs_c] = int'(if_c.out_data); idx_c[hs_c] = int'(if_c.out_idx); end
          hs_c++;
        end
        if (if_r.out_valid && out_ready) begin
          if (hs_r < 8) res_r[hs_r] = int'(if_r.out_data);
          hs_r++;
        end
        if (if_w.out_valid && out_ready) begin
          if (hs_w < 8) res_w[hs_w] = int'(if_w.out_data);
          hs_w++;
        end
        tick;
        n++;
      end
    end
    start = 1'b0; ld_valid = 1'b0; out_ready = 1'b1;
    tick;
  endtask

  task automatic set_base_data;
    ifm_a  = '{1, 2, 3, 0,  0, 1, 2, 3,  3, 0, 1, 2,  2, 3, 0, 1};
    kern_a = '{2, 0, 1,  0, 1, 2,  1, 0, 2};
  endtask

  task automatic check_corr(input string tag);
    int exp_v[4];
    exp_v = '{15, 16, 6, 15};
    n_checks++;
    if (hs_c !== 4) begin n_fail++; $display("FAIL %s_handshakes: got %0d expected 4", tag, hs_c); end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (res_c[k] !== exp_v[k] || idx_c[k] !== k) begin
        n_fail++;
        $display("FAIL %s_result[%0d]: got data %0d idx %0d expected data %0d idx %0d", tag, k, res_c[k], idx_c[k], exp_v[k], k);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick; tick;
    n_checks++; if (if_c.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", if_c.busy); end
    n_checks++; if (if_c.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b expected 0", if_c.out_valid); end
    n_checks++; if (if_c.out_idx !== 2'd0) begin n_fail++; $display("FAIL reset_out_idx: got %0d expected 0", if_c.out_idx); end
    n_checks++; if (if_c.out_data !== 8'd0) begin n_fail++; $display("FAIL reset_out_data: got %0d expected 0", if_c.out_data); end
    n_checks++; if (if_c.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b expected 0", if_c.done); end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_correlation;
    set_base_data();
    load_ifm();
    load_kern(8);
    run(-1, 0, 1'b0, 1'b1);
    check_corr("corr");
    n_checks++;
    if (done_at !== 14) begin n_fail++; $display("FAIL corr_latency: got %0d expected 14", done_at); end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (res_w[k] !== res_c[k] || hs_w !== 4) begin
        n_fail++; $display("FAIL corr_wrap[%0d]: got %0d expected %0d", k, res_w[k], res_c[k]);
      end
    end
  endtask

  task automatic test_rotate;
    int exp_v[4];
    exp_v = '{11, 12, 10, 11};
    for (int pass = 0; pass < 2; pass++) begin
      run(-1, 0, 1'b0, 1'b0);
      n_checks++;
      if (hs_r !== 4) begin n_fail++; $display("FAIL rot_handshakes: got %0d expected 4", hs_r); end
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (res_r[k] !== exp_v[k]) begin
          n_fail++; $display("FAIL rot_result[%0d] pass %0d: got %0d expected %0d", k, pass, res_r[k], exp_v[k]);
        end
      end
    end
    check_corr("rerun");
  endtask

  task automatic test_saturate;
    for (int i = 0; i < 16; i++) ifm_a[i] = 255;
    for (int i = 0; i < 9; i++) kern_a[i] = 255;
    load_ifm();
    load_kern(9);
    run(-1, 0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (res_c[k] !== 255) begin n_fail++; $display("FAIL sat[%0d]: got %0d expected 255", k, res_c[k]); end
      n_checks++;
      if (res_w[k] !== 9) begin n_fail++; $display("FAIL wrap[%0d]: got %0d expected 9", k, res_w[k]); end
    end
  endtask

  task automatic test_backpressure;
    set_base_data();
    load_ifm();
    load_kern(9);
    run(1, 5, 1'b0, 1'b0);
    n_checks++;
    if (n_stall !== 5) begin n_fail++; $display("FAIL bp_stall_cycles: got %0d expected 5", n_stall); end
    for (int s = 0; s < 5; s++) begin
      n_checks++;
      if (st_idx[s] !== 1 || st_data[s] !== 16) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got idx %0d data %0d expected idx 1 data 16", s, st_idx[s], st_data[s]);
      end
    end
    check_corr("bp");
    n_checks++;
    if (done_at !== 19) begin n_fail++; $display("FAIL bp_latency: got %0d expected 19", done_at); end
  endtask

  task automatic test_reset_mid;
    int seen;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick; tick; tick;
    rst = 1'b1;
    tick;
    n_checks++;
    if (if_c.busy !== 1'b0 || if_c.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL midrst_abort: got busy %0b out_valid %0b expected 0 0", if_c.busy, if_c.out_valid);
    end
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (if_c.done || if_c.busy || if_c.out_valid) seen = 1;
    end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL midrst_quiet: got activity %0d expected 0", seen); end
    set_base_data();
    load_ifm();
    load_kern(9);
    run(-1, 0, 1'b0, 1'b0);
    check_corr("midrst");
  endtask

  task automatic test_busy_ignore;
    run(-1, 0, 1'b1, 1'b0);
    check_corr("ignore");
    n_checks++;
    if (done_at !== 14) begin n_fail++; $display("FAIL ignore_latency: got %0d expected 14", done_at); end
    run(-1, 0, 1'b0, 1'b0);
    check_corr("ignore_rerun");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ld_valid = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0;
    start = 1'b0; out_ready = 1'b1;
    test_reset();
    test_correlation();
    test_rotate();
    test_saturate();
    test_backpressure();
    test_reset_mid();
    test_busy_ignore();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
